// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key expansion: one word per cycle through a single SubWord, stored in a word file.
// Round r is released once wptr >= 4r+4; a key is always accepted and restarts the schedule.
module aes_key_sched_ctrl #(
  parameter int Nk = 4,
  parameter int Nb = 4,
  parameter int Nr = Nk + 6,
  parameter int NW = Nb * (Nr + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Nk*32-1:0] key_in,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic            rk_req,
  input  logic [3:0]      rk_round,
  output logic            rk_valid,
  output logic [127:0]    rk_data,
  output logic            rk_err,
  output logic            busy,
  output logic            done
);
  localparam int PW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state;
  logic [PW-1:0] wptr;
  logic [2:0]    kidx;
  logic [7:0]    rcon;
  logic [31:0]   wf [NW];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map; 0 maps to 0 before the affine step
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(a, a);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic          load;
  logic [31:0]   prev_w, back_w, sub_in, sub_out, new_w;
  logic          rk_bad, rk_avail;
  logic [PW-1:0] rd_base;

  assign key_ready = 1'b1;
  assign load      = key_valid && key_ready;

  always_comb begin
    prev_w  = wf[wptr - PW'(1)];
    back_w  = wf[wptr - PW'(Nk)];
    sub_in  = (kidx == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = sub_word(sub_in);
    if (kidx == 3'd0)
      new_w = back_w ^ sub_out ^ {rcon, 24'h0};
    else if (Nk == 8 && kidx == 3'd4)
      new_w = back_w ^ sub_out;
    else
      new_w = back_w ^ prev_w;
  end

  always_comb begin
    rk_bad   = int'(rk_round) > Nr;
    rk_avail = int'(wptr) >= 4 * int'(rk_round) + 4;
    rd_base  = rk_bad ? '0 : PW'({rk_round, 2'b00});
  end

  // Word file has no reset: validity is tracked solely by wptr
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load) begin
        for (int i = 0; i < Nk; i++)
          wf[i] <= key_in[(Nk-1-i)*32 +: 32];
      end else if (state == EXPAND) begin
        wf[wptr] <= new_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wptr     <= '0;
      kidx     <= '0;
      rcon     <= 8'h01;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      if (rk_req) begin
        if (rk_bad) begin
          rk_err <= 1'b1;
        end else if (rk_avail) begin
          rk_valid <= 1'b1;
          rk_data  <= {wf[rd_base], wf[rd_base + PW'(1)],
                       wf[rd_base + PW'(2)], wf[rd_base + PW'(3)]};
        end
      end

      if (load) begin
        state <= EXPAND;
        wptr  <= PW'(Nk);
        kidx  <= '0;
        rcon  <= 8'h01;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        case (state)
          EXPAND: begin
            wptr <= wptr + PW'(1);
            kidx <= (kidx == 3'(Nk - 1)) ? 3'd0 : kidx + 3'd1;
            if (kidx == 3'd0) rcon <= xtime(rcon);
            if (wptr == PW'(NW - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl with Nk=4/6/8 instances checked against FIPS-197 vectors.
module tb_aes_key_sched_ctrl;
  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2_128  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] R0_192  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R1_192  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R0_256  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R2_256  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [255:0] key_bus   [3];
  logic         key_valid [3];
  logic         rk_req    [3];
  logic [3:0]   rk_round  [3];
  logic         key_ready [3];
  logic         rk_valid  [3];
  logic         rk_err    [3];
  logic         busy      [3];
  logic         done      [3];
  logic [127:0] rk_data   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NK = 4 + 2 * g;
    aes_key_sched_ctrl #(.Nk(NK)) dut (
      .clk       (clk),
      .reset     (reset),
      .key_in    (key_bus[g][255 -: NK*32]),
      .key_valid (key_valid[g]),
      .key_ready (key_ready[g]),
      .rk_req    (rk_req[g]),
      .rk_round  (rk_round[g]),
      .rk_valid  (rk_valid[g]),
      .rk_data   (rk_data[g]),
      .rk_err    (rk_err[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  typedef struct {
    string        tag;
    logic [127:0] data;
  } exp_t;

  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_exp(input string tag, input logic [127:0] data);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic accept(input int i, input logic [255:0] key);
    key_bus[i]   = key;
    key_valid[i] = 1'b1;
    @(posedge clk); #1;
    key_valid[i] = 1'b0;
  endtask

  // Waits for rk_valid on instance i; pops the scoreboard and compares the data
  task automatic wait_valid(input int i, input int max, output int vcyc, output int dcyc);
    exp_t e;
    vcyc = -1;
    dcyc = -1;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk); #1;
      if (done[i] && dcyc < 0) dcyc = c;
      if (rk_valid[i]) begin
        vcyc      = c;
        rk_req[i] = 1'b0;
        if (sb.size() == 0) begin
          chk("sb_underflow", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          chk(e.tag, rk_data[i], e.data);
        end
        break;
      end
    end
    if (vcyc < 0) begin
      rk_req[i] = 1'b0;
      if (sb.size() > 0) e = sb.pop_front();
    end
  endtask

  task automatic serve(input int i, input int r, input logic [127:0] exp, input int lat,
                       input string tag);
    int v, d;
    rk_round[i] = 4'(r);
    rk_req[i]   = 1'b1;
    push_exp(tag, exp);
    wait_valid(i, 100, v, d);
    chk({tag, "_lat"}, v, lat);
  endtask

  // Accepts a key, then holds a request for round r from the next cycle
  task automatic run_key(input int i, input logic [255:0] key, input int r,
                         input logic [127:0] exp, input int done_at, input int valid_at,
                         input string tag);
    int v, d;
    accept(i, key);
    chk({tag, "_busy"}, busy[i], 1);
    chk({tag, "_done_lo"}, done[i], 0);
    rk_round[i] = 4'(r);
    rk_req[i]   = 1'b1;
    push_exp(tag, exp);
    wait_valid(i, 200, v, d);
    chk({tag, "_done_cyc"}, d + 1, done_at);
    chk({tag, "_vld_cyc"}, v + 1, valid_at);
  endtask

  task automatic err_pulse(input int i, input int r, input logic [127:0] prev, input string tag);
    rk_round[i] = 4'(r);
    rk_req[i]   = 1'b1;
    @(posedge clk); #1;
    rk_req[i] = 1'b0;
    chk({tag, "_err"}, rk_err[i], 1);
    chk({tag, "_vld"}, rk_valid[i], 0);
    chk({tag, "_data"}, rk_data[i], prev);
    @(posedge clk); #1;
    chk({tag, "_err_once"}, rk_err[i], 0);
  endtask

  initial begin
    int bad, v, d;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_bus[i]   = '0;
      key_valid[i] = 1'b0;
      rk_req[i]    = 1'b0;
      rk_round[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_rk_valid", rk_valid[0], 0);
    chk("rst_rk_err", rk_err[0], 0);
    chk("rst_rk_data", rk_data[0], 0);
    reset = 1'b0;

    // AES-128 full schedule with an early round-10 request
    run_key(0, {K128, 128'h0}, 10, R10_128, 41, 42, "k128_r10");
    serve(0, 1, R1_128, 1, "k128_r1");
    serve(0, 0, K128, 1, "k128_r0");
    serve(0, 2, R2_128, 1, "k128_r2");
    err_pulse(0, 11, R2_128, "k128_r11");

    // Rounds released while expansion is still running
    accept(0, {K128, 128'h0});
    serve(0, 0, K128, 1, "early_r0");
    serve(0, 1, R1_128, 4, "early_r1");

    // Abort: a zero key is replaced mid-expansion by the FIPS key
    accept(0, '0);
    rk_round[0] = 4'd10;
    rk_req[0]   = 1'b1;
    push_exp("abort_r10", R10_128);
    bad = 0;
    repeat (18) begin
      @(posedge clk); #1;
      if (rk_valid[0]) bad++;
    end
    accept(0, {K128, 128'h0});
    chk("abort_no_old_serve", bad, 0);
    wait_valid(0, 100, v, d);
    chk("abort_vld_cyc", v + 1, 42);

    // Reset in the middle of an expansion
    accept(0, {K128, 128'h0});
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    chk("mid_rst_key_ready", key_ready[0], 1);
    chk("mid_rst_rk_valid", rk_valid[0], 0);
    chk("mid_rst_rk_data", rk_data[0], 0);
    reset = 1'b0;
    err_pulse(0, 15, 128'h0, "mid_rst_r15");
    rk_round[0] = 4'd0;
    rk_req[0]   = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rk_valid[0]) bad++;
    end
    rk_req[0] = 1'b0;
    chk("mid_rst_no_words", bad, 0);

    // AES-192
    run_key(1, {K192, 64'h0}, 12, R12_192, 47, 48, "k192_r12");
    serve(1, 1, R1_192, 1, "k192_r1");
    serve(1, 0, R0_192, 1, "k192_r0");

    // AES-256
    run_key(2, K256, 14, R14_256, 53, 54, "k256_r14");
    serve(2, 2, R2_256, 1, "k256_r2");
    serve(2, 0, R0_256, 1, "k256_r0");
    err_pulse(2, 15, R0_256, "k256_r15");

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
